// File: rtl/panxi_spsram_bw_if.sv
// panxi_spsram_bw_if: request/response bus of the PANXI single-port byte-write SRAM
interface panxi_spsram_bw_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                    CEN;
    logic                    GWEN;
    logic [DATA_WIDTH/8-1:0] AWEN;
    logic [ADDR_WIDTH-1:0]   AADDR;
    logic [DATA_WIDTH-1:0]   ADATA_XI;
    logic [DATA_WIDTH-1:0]   ADATA_XO;
    logic                    ARVALID;
    logic                    ARDY;
    modport master (output CEN, GWEN, AWEN, AADDR, ADATA_XI, input ADATA_XO, ARVALID, ARDY);
    modport slave (input CEN, GWEN, AWEN, AADDR, ADATA_XI, output ADATA_XO, ARVALID, ARDY);
endinterface

// File: rtl/panxi_spsram_bw.sv
// panxi_spsram_bw: single-port SRAM with byte writes, optional output register and post-reset zero fill
module panxi_spsram_bw #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int OUT_REG    = 0,
    parameter int INIT_ZERO  = 1
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    panxi_spsram_bw_if.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;
    typedef enum logic {INIT, READY} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ardy_q, ardy_d;
    logic                  rv1_q, rv1_d, rv2_q, rv2_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range, req, rd_en, wr_en, init;
    logic [NB-1:0]         be;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata, rword;
    always_comb begin
        init     = state_q == INIT;
        in_range = int'(bus.AADDR) < DEPTH;
        req      = ardy_q & ~bus.CEN;
        rd_en    = req & bus.GWEN;
        wr_en    = init | (req & ~bus.GWEN & in_range);
        waddr    = init ? cnt_q : bus.AADDR;
        be       = init ? '1 : ~bus.AWEN;
        wdata    = init ? '0 : bus.ADATA_XI;
        rword    = in_range ? mem[bus.AADDR] : '0;
        state_d  = (init && cnt_q == ADDR_WIDTH'(DEPTH - 1)) ? READY : state_q;
        cnt_d    = init ? cnt_q + 1'b1 : cnt_q;
        ardy_d   = state_d == READY;
        rv1_d    = rd_en;
        rd1_d    = rd_en ? rword : rd1_q;
        rv2_d    = rv1_q;
        rd2_d    = rv1_q ? rd1_q : rd2_q;
    end
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= INIT_ZERO != 0 ? INIT : READY;
            cnt_q   <= '0;
            ardy_q  <= INIT_ZERO == 0;
            rv1_q   <= 1'b0;
            rv2_q   <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ardy_q  <= ardy_d;
            rv1_q   <= rv1_d;
            rv2_q   <= rv2_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end
    always_ff @(posedge ACLK) begin
        if (wr_en)
            for (int b = 0; b < NB; b++)
                if (be[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
    assign bus.ADATA_XO = OUT_REG != 0 ? rd2_q : rd1_q;
    assign bus.ARVALID  = OUT_REG != 0 ? rv2_q : rv1_q;
    assign bus.ARDY     = ardy_q;
endmodule
